// File: rtl/layer_compositor.sv
// Two-stage per-pixel layer compositor with priority select over a background colour.
// Optional per-frame layer collision reporting is built when LAYER_COMPOSITOR_COLLISION_EN is defined.
module layer_compositor #(
  parameter int unsigned N_LAYERS = 4,
  parameter logic [7:0]  BG_RED   = 8'h00,
  parameter logic [7:0]  BG_GREEN = 8'h00,
  parameter logic [7:0]  BG_BLUE  = 8'h20
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_de,
  input  logic                      i_v_sync,
  input  logic [N_LAYERS-1:0]       i_layer_hit,
  input  logic [24*N_LAYERS-1:0]    i_layer_rgb,
  output logic [7:0]                o_red,
  output logic [7:0]                o_green,
  output logic [7:0]                o_blue,
  output logic                      o_de,
  output logic                      o_v_sync,
  output logic [N_LAYERS-1:0]       o_collision_mask,
  output logic                      o_collision_valid
);

  // Stage 1: capture inputs; hits are qualified by active video here.
  logic [N_LAYERS-1:0]    hit_q;
  logic [24*N_LAYERS-1:0] rgb_q;
  logic                   de_q;
  logic                   vs_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hit_q <= '0;
      rgb_q <= '0;
      de_q  <= 1'b0;
      vs_q  <= 1'b0;
    end else begin
      hit_q <= i_layer_hit & {N_LAYERS{i_de}};
      rgb_q <= i_layer_rgb;
      de_q  <= i_de;
      vs_q  <= i_v_sync;
    end
  end

  // Stage 2: priority select. Only a hit layer's colour is ever routed, so
  // undriven colours of non-hit layers never reach the outputs.
  logic [23:0] pix_d;
  logic [23:0] pix_q;
  logic        de_out_q;
  logic        vs_out_q;
  logic        found;

  always_comb begin
    pix_d = '0;
    found = 1'b0;
    if (de_q) begin
      pix_d = {BG_RED, BG_GREEN, BG_BLUE};
      for (int unsigned k = 0; k < N_LAYERS; k++) begin
        if (!found && hit_q[k]) begin
          pix_d = rgb_q[24*k +: 24];
          found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pix_q    <= '0;
      de_out_q <= 1'b0;
      vs_out_q <= 1'b0;
    end else begin
      pix_q    <= pix_d;
      de_out_q <= de_q;
      vs_out_q <= vs_q;
    end
  end

  assign o_red    = pix_q[23:16];
  assign o_green  = pix_q[15:8];
  assign o_blue   = pix_q[7:0];
  assign o_de     = de_out_q;
  assign o_v_sync = vs_out_q;

`ifdef LAYER_COMPOSITOR_COLLISION_EN
  localparam logic [N_LAYERS-1:0] One = 1;

  logic [N_LAYERS-1:0] active;
  logic [N_LAYERS-1:0] contrib;
  logic [N_LAYERS-1:0] acc_d;
  logic [N_LAYERS-1:0] acc_q;
  logic [N_LAYERS-1:0] mask_d;
  logic [N_LAYERS-1:0] mask_q;
  logic                vs_prev_q;
  logic                frame_edge;
  logic                valid_q;

  always_comb begin
    active     = i_layer_hit & {N_LAYERS{i_de}};
    // Clearing the lowest set bit leaves something only if two or more layers hit.
    contrib    = ((active & (active - One)) != '0) ? active : '0;
    frame_edge = i_v_sync & ~vs_prev_q;
    acc_d      = frame_edge ? contrib : (acc_q | contrib);
    mask_d     = frame_edge ? acc_q : mask_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc_q     <= '0;
      mask_q    <= '0;
      vs_prev_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      mask_q    <= mask_d;
      vs_prev_q <= i_v_sync;
      valid_q   <= frame_edge;
    end
  end

  assign o_collision_mask  = mask_q;
  assign o_collision_valid = valid_q;
`else
  assign o_collision_mask  = '0;
  assign o_collision_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: directed cases followed by randomized pixels,
// compared each cycle against a behavioural model of compositing and frame collisions.
module tb_layer_compositor;

`ifdef LAYER_COMPOSITOR_COLLISION_EN
  localparam bit CollEn = 1'b1;
`else
  localparam bit CollEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        de;
  logic        vs;
  logic [3:0]  hit;
  logic [95:0] rgb;
  logic [7:0]  o_red, o_green, o_blue;
  logic        o_de, o_v_sync;
  logic [3:0]  o_mask;
  logic        o_valid;

  layer_compositor #(
    .N_LAYERS (4),
    .BG_RED   (8'h00),
    .BG_GREEN (8'h00),
    .BG_BLUE  (8'h20)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_de              (de),
    .i_v_sync          (vs),
    .i_layer_hit       (hit),
    .i_layer_rgb       (rgb),
    .o_red             (o_red),
    .o_green           (o_green),
    .o_blue            (o_blue),
    .o_de              (o_de),
    .o_v_sync          (o_v_sync),
    .o_collision_mask  (o_mask),
    .o_collision_valid (o_valid)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [23:0] pipe_pix, exp_pix;
  bit          pipe_de, exp_de, pipe_vs, exp_vs;
  logic [3:0]  acc_m, exp_mask;
  bit          exp_valid, vs_prev_m;

  function automatic logic [23:0] compose(input bit d, input logic [3:0] h, input logic [95:0] c);
    if (!d) return 24'h000000;
    for (int k = 0; k < 4; k++) if (h[k]) return c[24*k +: 24];
    return 24'h000020;
  endfunction

  function automatic logic [95:0] mkrgb(input logic [3:0] h);
    logic [95:0] c;
    for (int k = 0; k < 4; k++) c[24*k +: 24] = h[k] ? 24'($urandom) : 24'hxxxxxx;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input bit d, input bit v, input logic [3:0] h, input logic [95:0] c);
    de  = d;
    vs  = v;
    hit = h;
    rgb = c;
  endtask

  task automatic model_step();
    logic [3:0] ov, contrib;
    if (!rst_n) begin
      pipe_pix = '0; exp_pix = '0; pipe_de = 0; exp_de = 0; pipe_vs = 0; exp_vs = 0;
      acc_m = '0; exp_mask = '0; exp_valid = 0; vs_prev_m = 0;
    end else begin
      exp_pix  = pipe_pix;
      exp_de   = pipe_de;
      exp_vs   = pipe_vs;
      pipe_pix = compose(de, hit, rgb);
      pipe_de  = de;
      pipe_vs  = vs;
      if (CollEn) begin
        ov      = de ? hit : 4'b0000;
        contrib = ($countones(ov) >= 2) ? ov : 4'b0000;
        if (vs && !vs_prev_m) begin
          exp_mask  = acc_m;
          acc_m     = contrib;
          exp_valid = 1'b1;
        end else begin
          acc_m     = acc_m | contrib;
          exp_valid = 1'b0;
        end
        vs_prev_m = vs;
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    chk({tag, "_rgb"},   {8'h0, o_red, o_green, o_blue}, {8'h0, exp_pix});
    chk({tag, "_de"},    {31'h0, o_de},     {31'h0, exp_de});
    chk({tag, "_vs"},    {31'h0, o_v_sync}, {31'h0, exp_vs});
    chk({tag, "_mask"},  {28'h0, o_mask},   {28'h0, exp_mask});
    chk({tag, "_valid"}, {31'h0, o_valid},  {31'h0, exp_valid});
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0;
    drive(0, 0, 4'b0000, '0);
    pipe_pix = '0; exp_pix = '0; acc_m = '0; exp_mask = '0;
    repeat (3) tick("reset");

    rst_n = 1'b1;
    repeat (3) tick("idle");
    drive(1, 0, 4'b0000, mkrgb(4'b0000));
    repeat (3) tick("bg");
    chk("bg_const", {8'h0, o_red, o_green, o_blue}, 32'h000020);

    // Priority with undriven colours on non-hit layers
    drive(1, 0, 4'b0110, {24'hxxxxxx, 24'h00FF00, 24'hFF0000, 24'hxxxxxx});
    tick("prio_a");
    drive(1, 0, 4'b1000, {24'h123456, 24'hxxxxxx, 24'hxxxxxx, 24'hxxxxxx});
    tick("prio_b");
    chk("prio_l1", {8'h0, o_red, o_green, o_blue}, 32'hFF0000);
    drive(0, 0, 4'b1111, mkrgb(4'b1111));
    tick("de_off");
    chk("prio_l3", {8'h0, o_red, o_green, o_blue}, 32'h123456);
    drive(1, 0, 4'b0000, mkrgb(4'b0000));
    tick("de_on");
    chk("de_off_black", {8'h0, o_red, o_green, o_blue}, 32'h000000);

    // Flush the accumulated frame, then a clean collision frame
    drive(1, 1, 4'b0000, mkrgb(4'b0000));
    tick("flush_edge");
    drive(1, 0, 4'b0000, mkrgb(4'b0000));
    tick("flush_low");
    drive(1, 0, 4'b0101, mkrgb(4'b0101));
    tick("ovl_0101");
    drive(1, 0, 4'b0000, mkrgb(4'b0000));
    tick("ovl_gap");
    drive(1, 1, 4'b0000, mkrgb(4'b0000));
    tick("edge1");
    chk("frame_mask", {28'h0, o_mask}, CollEn ? 32'h5 : 32'h0);
    chk("frame_valid", {31'h0, o_valid}, {31'h0, CollEn});
    drive(1, 0, 4'b0000, mkrgb(4'b0000));
    tick("post_edge1");
    drive(1, 1, 4'b0000, mkrgb(4'b0000));
    tick("edge2");
    chk("empty_mask", {28'h0, o_mask}, 32'h0);
    drive(1, 0, 4'b0000, mkrgb(4'b0000));
    tick("post_edge2");

    // Overlap on the edge cycle belongs to the new frame; long v_sync gives one pulse
    drive(1, 1, 4'b0011, mkrgb(4'b0011));
    pulses = 0;
    tick("edge3");
    chk("edge_excl", {28'h0, o_mask}, 32'h0);
    pulses += int'(o_valid);
    for (int i = 0; i < 9; i++) begin
      drive(1, 1, 4'b0000, mkrgb(4'b0000));
      tick("vs_hold");
      pulses += int'(o_valid);
    end
    chk("one_pulse", pulses, CollEn ? 32'd1 : 32'd0);
    drive(1, 0, 4'b0000, mkrgb(4'b0000));
    tick("vs_low");
    drive(1, 1, 4'b0000, mkrgb(4'b0000));
    tick("edge4");
    chk("edge_incl", {28'h0, o_mask}, CollEn ? 32'h3 : 32'h0);

    // Reset mid-frame discards accumulated overlaps
    drive(1, 0, 4'b1100, mkrgb(4'b1100));
    tick("ovl_1100");
    rst_n = 1'b0;
    drive(0, 0, 4'b0000, '0);
    tick("mid_rst");
    rst_n = 1'b1;
    tick("post_rst");
    drive(1, 1, 4'b0000, mkrgb(4'b0000));
    tick("edge_rst");
    chk("rst_mask", {28'h0, o_mask}, 32'h0);
    chk("rst_valid", {31'h0, o_valid}, {31'h0, CollEn});

    // Randomized pixels with periodic frames and occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] h;
      h     = 4'($urandom);
      rst_n = ($urandom_range(199) != 0);
      drive($urandom_range(9) != 0, (i % 97) < 3, h, mkrgb(h));
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer_compositor.md
# layer_compositor

Per-pixel compositor between the sprite and terrain renderers and the video output encoder. Takes N_LAYERS colour/hit pairs for the current pixel, selects the highest-priority visible layer over a background colour, and registers the result with matched sync/enable delay. It also accumulates per-layer overlap (collision) flags across a frame and publishes them once per frame on the rising edge of vertical sync, for game logic.

## Interface
- N_LAYERS, 4, number of input layers; layer 0 has highest priority
- BG_RED, 8'h00, background red when no layer hits
- BG_GREEN, 8'h00, background green
- BG_BLUE, 8'h20, background blue
- i_clk  input  1  pixel clock; all logic on rising edge
- i_rst_n  input  1  synchronous, active-low reset
- i_de  input  1  active-video enable for the current pixel
- i_v_sync  input  1  vertical sync, active high, same pixel timing as i_de
- i_layer_hit  input  N_LAYERS  per-layer visible-pixel flag (renderer o_sprite_hit)
- i_layer_rgb  input  24*N_LAYERS  per-layer colour; layer k at bits [24k+23:24k], packed {red,green,blue}
- o_red / o_green / o_blue  output  8 each  composited pixel colour
- o_de  output  1  i_de delayed to align with colour
- o_v_sync  output  1  i_v_sync delayed to align with colour
- o_collision_mask  output  N_LAYERS  bit k set: layer k overlapped another layer at least once during the previous frame
- o_collision_valid  output  1  one-cycle pulse when o_collision_mask updates

## Operation
- Stage 1 (register): hit_q = i_layer_hit & {N_LAYERS{i_de}}; rgb_q, de_q and vs_q capture i_layer_rgb, i_de and i_v_sync.
- Stage 2 (select): lowest-index k with hit_q[k] set drives its rgb; no hit with de_q high gives {BG_RED,BG_GREEN,BG_BLUE}; de_q low gives 0,0,0. o_de and o_v_sync follow de_q and vs_q.
- The colour of a non-hit layer is never used. Renderers drive X there, and no X may reach the outputs while o_de is high.
- Collision contribution per cycle: if at least two bits of (i_layer_hit & i_de) are set, contrib = those bits; otherwise contrib = 0.
- Accumulator acc (N_LAYERS bits): acc <= acc | contrib on each cycle.
- Frame edge: edge = i_v_sync & ~vs_prev, where vs_prev holds the previous cycle's i_v_sync.
  - On an edge cycle: o_collision_mask <= acc (excluding that cycle's contrib); acc <= contrib, so same-cycle contributions count toward the new frame.
  - o_collision_valid <= edge.
- o_collision_mask holds its value between edges.
- Reset (any time, including mid-frame): all pipeline registers, acc and vs_prev go to 0. The first edge after reset publishes only collisions seen after reset.
- vs_prev resets to 0, so i_v_sync high in the first cycle after reset counts as an edge.

## Timing
- Latency is 2 cycles, from an input sampled at edge N to o_red/o_green/o_blue/o_de/o_v_sync valid after edge N+1. Throughput is one pixel per clock, with no stalls and no backpressure.
- o_collision_mask and o_collision_valid update 1 cycle after i_v_sync is sampled rising.
- o_collision_valid is high for exactly one cycle per rising edge, even if i_v_sync stays high for many cycles.
- Reset values: o_red = o_green = o_blue = 0, o_de = 0, o_v_sync = 0, o_collision_mask = 0, o_collision_valid = 0.

## Configuration
- LAYER_COMPOSITOR_COLLISION_EN
  - Defined: collision accumulator, edge detect and both collision outputs are implemented as above.
  - Undefined: no accumulator or edge logic is built; o_collision_mask is tied to 0 and o_collision_valid to 0. Colour path and latency are unchanged.

## Test plan
- Reset then idle, i_de = 0: all outputs 0. Then i_de = 1 with no hits: after 2 cycles, rgb = 00/00/20 and o_de = 1.
- Priority and X masking: hit = 4'b0110, layer1 = FF0000, layer2 = 00FF00, layers 0 and 3 rgb = X → after 2 cycles, rgb = FF/00/00 with no X bits. With hit = 4'b1000 and layer3 = 123456 → 12/34/56.
- i_de = 0 with hit = 4'b1111 → rgb = 000000, and no collision is accumulated.
- Collision frame (macro defined): hit = 4'b0101 with i_de = 1 for one pixel, then i_v_sync rises → one cycle later, mask = 4'b0101 and valid pulses for 1 cycle. At the next edge with no overlaps → mask = 0000.
- Edge-cycle overlap: hit = 4'b0011 with de = 1 on the same cycle as the v_sync rise → published mask excludes it; the following frame's mask = 0011. Holding v_sync high for 10 cycles gives exactly one valid pulse.
- Reset mid-frame after an overlap of 4'b1100, then a v_sync edge → mask = 0000. With the macro undefined, the same overlap stimulus leaves mask = 0 and valid = 0.
